// File: rtl/seg7_display_ctrl_pkg.sv
// Shared display definitions: glyphs, converter states and state-code limits.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_display_ctrl_pkg;

    localparam int VALUE_W = 8;
    localparam int STATE_W = 3;

    // Counter FSM codes above this have no numeric glyph and show a dash
    localparam logic [STATE_W-1:0] STATE_GLYPH_MAX = 3'd4;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    typedef struct packed {
        logic [1:0] hund;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] state_glyph(input logic [STATE_W-1:0] s);
        return (s <= STATE_GLYPH_MAX) ? digit_glyph({1'b0, s}) : GLYPH_DASH;
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Display controller bus: slow-domain value/state in, multiplexed display drive out.
interface seg7_display_ctrl_if;
    import seg7_display_ctrl_pkg::*;

    logic [VALUE_W-1:0] value_i;
    logic [STATE_W-1:0] state_i;
    logic [3:0]         an_o;
    logic [6:0]         seg_o;
    logic               dp_o;
    logic               busy_o;

    modport master (output value_i, state_i, input an_o, seg_o, dp_o, busy_o);
    modport slave  (input value_i, state_i, output an_o, seg_o, dp_o, busy_o);

endinterface

// File: rtl/seg7_display_ctrl_bin2bcd_seq.sv
// Sequential 8-bit double-dabble: 1 load cycle, 8 shift cycles, 1 done cycle.
// start is only honoured while idle; done is a one-cycle strobe with bcd valid.
module bin2bcd_seq
    import seg7_display_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output bcd_t               bcd
);

    conv_state_e        state, state_nxt;
    logic [2:0]         shift_cnt;
    logic [9:0]         acc;
    logic [VALUE_W-1:0] sreg;
    logic [3:0]         tens_adj;
    logic [3:0]         units_adj;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= CONV_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (shift_cnt == 3'd7) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != CONV_IDLE);
        done = (state == CONV_DONE);
    end

    // Hundreds never exceeds 2, so only tens and units need the add-3 correction
    always_comb begin
        tens_adj  = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
        units_adj = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc       <= '0;
            sreg      <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        sreg      <= bin;
                        shift_cnt <= '0;
                    end
                end
                CONV_SHIFT: begin
                    acc       <= {acc[8], tens_adj, units_adj, sreg[VALUE_W-1]};
                    sreg      <= {sreg[VALUE_W-2:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = '{hund: acc[9:8], tens: acc[7:4], units: acc[3:0]};

endmodule

// File: rtl/seg7_display_ctrl.sv
// 4-digit multiplexed 7-segment driver: 3-digit decimal value plus state code digit.
// Slow inputs pass a two-stage stability check; a changed value is redisplayed 10 cycles after it is accepted.
module seg7_display_ctrl
    import seg7_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic                clk_i,
    input  logic                rst_i,
    seg7_display_ctrl_if.slave  bus
);

    localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [STATE_W+VALUE_W-1:0] s1, s2;
    logic                       stable;
    logic [VALUE_W-1:0]         last_val;
    logic [STATE_W-1:0]         disp_state;
    bcd_t                       disp_bcd;
    bcd_t                       conv_bcd;
    logic                       conv_start;
    logic                       conv_busy;
    logic                       conv_done;

    logic [PW-1:0]              presc;
    logic [1:0]                 digit_idx;
    logic [3:0]                 an_nxt, an_q;
    logic [6:0]                 seg_nxt, seg_q;
    logic                       dp_nxt, dp_q;

    // Both stages must agree on all 11 bits so a half-updated slow-domain word is never used
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {bus.state_i, bus.value_i};
            s2 <= s1;
        end
    end

    assign stable     = (s1 == s2);
    assign conv_start = stable && !conv_busy && (s2[VALUE_W-1:0] != last_val);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_val   <= '0;
            disp_state <= '0;
            disp_bcd   <= '0;
        end else begin
            if (stable)     disp_state <= s2[STATE_W+VALUE_W-1:VALUE_W];
            if (conv_start) last_val   <= s2[VALUE_W-1:0];
            if (conv_done)  disp_bcd   <= conv_bcd;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (conv_start),
        .bin   (s2[VALUE_W-1:0]),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (presc == PRESC_LAST) begin
            presc     <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            presc     <= presc + PW'(1);
        end
    end

    always_comb begin
        an_nxt  = ~(4'b0001 << digit_idx);
        seg_nxt = GLYPH_BLANK;
        dp_nxt  = 1'b1;
        case (digit_idx)
            2'd0: seg_nxt = digit_glyph(disp_bcd.units);
            2'd1: seg_nxt = (BLANK_LZ && disp_bcd.hund == 2'd0 && disp_bcd.tens == 4'd0)
                            ? GLYPH_BLANK : digit_glyph(disp_bcd.tens);
            2'd2: seg_nxt = (BLANK_LZ && disp_bcd.hund == 2'd0)
                            ? GLYPH_BLANK : digit_glyph({2'b00, disp_bcd.hund});
            default: begin
                seg_nxt = state_glyph(disp_state);
                dp_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            an_q  <= 4'b1111;
            seg_q <= GLYPH_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an_o   = an_q;
    assign bus.seg_o  = seg_q;
    assign bus.dp_o   = dp_q;
    assign bus.busy_o = conv_start | conv_busy;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: two instances (leading-zero blanking on/off) checked against a decimal display model.
module tb_seg7_display_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic [2:0] state;
    int         checks;
    int         errors;

    seg7_display_ctrl_if bus_lz ();
    seg7_display_ctrl_if bus_nz ();

    assign bus_lz.value_i = value;
    assign bus_lz.state_i = state;
    assign bus_nz.value_i = value;
    assign bus_nz.state_i = state;

    seg7_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_lz (.clk_i(clk), .rst_i(rst), .bus(bus_lz.slave));
    seg7_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nz (.clk_i(clk), .rst_i(rst), .bus(bus_nz.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {dp, seg} for one digit position, from the decimal value directly
    function automatic logic [7:0] model_digit(input int v, input int st, input bit blz, input int idx);
        case (idx)
            0:       return {1'b1, ref_glyph(v % 10)};
            1:       return {1'b1, (blz && v < 10)  ? ref_glyph(-1) : ref_glyph((v / 10) % 10)};
            2:       return {1'b1, (blz && v < 100) ? ref_glyph(-1) : ref_glyph(v / 100)};
            default: return {1'b0, (st <= 4) ? ref_glyph(st) : ref_glyph(10)};
        endcase
    endfunction

    function automatic int an_to_idx(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Returns the number of consecutive busy samples (0 if busy never rose)
    task automatic wait_conversion(output int n);
        n = 0;
        for (int i = 0; i < 60 && bus_lz.busy_o !== 1'b1; i++) @(negedge clk);
        while (bus_lz.busy_o === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        value = 8'd0;
        state = 3'd0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o, bus_lz.busy_o} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: an/seg/dp/busy got %b %b %b %b expected 1111 1111111 1 0",
                     bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o, bus_lz.busy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o} !== {4'b1110, 7'b1000000, 1'b1}) begin
            errors++;
            $display("FAIL first_drive: an/seg/dp got %b %b %b expected 1110 1000000 1",
                     bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o);
        end
    endtask

    task automatic test_convert_255();
        int n;
        logic [3:0] exp_an;
        @(negedge clk);
        value = 8'd255;
        state = 3'd3;
        wait_conversion(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL busy_len_255: got %0d cycles expected 10", n);
        end
        for (int i = 0; i < 40 && bus_lz.an_o !== 4'b0111; i++) @(negedge clk);
        for (int i = 0; i < 40 && bus_lz.an_o !== 4'b1110; i++) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_an = ~(4'b0001 << (i / 4));
            checks++;
            if (bus_lz.an_o !== exp_an || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(255, 3, 1'b1, i / 4)) begin
                errors++;
                $display("FAIL scan_255[%0d]: an/dp+seg got %b %b expected %b %b", i,
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, exp_an, model_digit(255, 3, 1'b1, i / 4));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank_lz();
        int n;
        int idx;
        value = 8'd7;
        wait_conversion(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL busy_len_7: got %0d cycles expected 10", n);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(7, 3, 1'b1, idx)) begin
                errors++;
                $display("FAIL blank_lz_7: an %b dp+seg got %b expected %b",
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(7, 3, 1'b1, idx));
            end
            idx = an_to_idx(bus_nz.an_o);
            checks++;
            if (idx < 0 || {bus_nz.dp_o, bus_nz.seg_o} !== model_digit(7, 3, 1'b0, idx)) begin
                errors++;
                $display("FAIL no_blank_7: an %b dp+seg got %b expected %b",
                         bus_nz.an_o, {bus_nz.dp_o, bus_nz.seg_o}, model_digit(7, 3, 1'b0, idx));
            end
        end
    endtask

    task automatic test_zero_dash();
        int n;
        int idx;
        value = 8'd0;
        state = 3'd6;
        wait_conversion(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL busy_len_0: got %0d cycles expected 10", n);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(0, 6, 1'b1, idx)) begin
                errors++;
                $display("FAIL zero_dash: an %b dp+seg got %b expected %b",
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(0, 6, 1'b1, idx));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int idx;
        value = 8'd100;
        state = 3'd2;
        for (int i = 0; i < 60 && bus_lz.busy_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus_lz.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: busy got %b expected 1", bus_lz.busy_o);
        end
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (n == 4) value = 8'd42;
        end
        checks++;
        if (bus_lz.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_busy: busy got %b expected 1", bus_lz.busy_o);
        end
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(100, 2, 1'b1, idx)) begin
                errors++;
                $display("FAIL b2b_first_100[%0d]: an %b dp+seg got %b expected %b", k,
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(100, 2, 1'b1, idx));
            end
            checks++;
            if (bus_lz.busy_o !== (k <= 9)) begin
                errors++;
                $display("FAIL b2b_second_busy[%0d]: busy got %b expected %b", k, bus_lz.busy_o, (k <= 9));
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(42, 2, 1'b1, idx)) begin
                errors++;
                $display("FAIL b2b_then_42: an %b dp+seg got %b expected %b",
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(42, 2, 1'b1, idx));
            end
        end
    endtask

    task automatic test_unstable();
        int idx;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom_range(43, 255));
        b = 8'($urandom_range(0, 41));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            value = (i % 2 == 0) ? a : b;
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (bus_lz.busy_o !== 1'b0 || idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(42, 2, 1'b1, idx)) begin
                errors++;
                $display("FAIL unstable_hold: busy %b an %b dp+seg got %b expected busy 0 dp+seg %b",
                         bus_lz.busy_o, bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(42, 2, 1'b1, idx));
            end
        end
        value = 8'd42;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus_lz.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL unstable_settle_busy: busy got %b expected 0", bus_lz.busy_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int idx;
        int v;
        v = int'($urandom_range(1, 255));
        if (v == 42) v = 43;
        value = 8'(v);
        state = 3'($urandom_range(0, 7));
        for (int i = 0; i < 60 && bus_lz.busy_o !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o, bus_lz.busy_o} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: an/seg/dp/busy got %b %b %b %b expected 1111 1111111 1 0",
                     bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o, bus_lz.busy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o} !== {4'b1110, 7'b1000000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_first: an/seg/dp got %b %b %b expected 1110 1000000 1",
                     bus_lz.an_o, bus_lz.seg_o, bus_lz.dp_o);
        end
        wait_conversion(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL reset_mid_redetect: got %0d busy cycles expected 10", n);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx = an_to_idx(bus_lz.an_o);
            checks++;
            if (idx < 0 || {bus_lz.dp_o, bus_lz.seg_o} !== model_digit(v, int'(state), 1'b1, idx)) begin
                errors++;
                $display("FAIL reset_mid_scan v=%0d: an %b dp+seg got %b expected %b", v,
                         bus_lz.an_o, {bus_lz.dp_o, bus_lz.seg_o}, model_digit(v, int'(state), 1'b1, idx));
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        value  = 8'd0;
        state  = 3'd0;
        checks = 0;
        errors = 0;
        test_reset();
        test_convert_255();
        test_blank_lz();
        test_zero_dash();
        test_back_to_back();
        test_unstable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
